uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter WD_SIZE, default `WD_SIZE (8): word width, equal to receiver word width.
REQ-002 SHALL have parameter DEPTH, default `RX_FIFO_DEPTH (16): entry count, power of two, 2..256.
REQ-003 SHALL have parameter THRESH, default DEPTH/2: fill threshold for irq_o, 1..DEPTH.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_data_i  input  WD_SIZE  received word from receiver bus_data_o.
REQ-007 wr_vld_i  input  1  one-cycle write strobe from receiver vld_data_o, no backpressure.
REQ-008 rd_data_o  output  WD_SIZE  head-of-queue word.
REQ-009 rd_vld_o  output  1  head word valid (queue non-empty).
REQ-010 rd_rdy_i  input  1  consumer ready; pop when rd_vld_o and rd_rdy_i both 1.
REQ-011 level_o  output  clog2(DEPTH)+1  current occupancy 0..DEPTH.
REQ-012 full_o  output  1  level_o == DEPTH.
REQ-013 empty_o  output  1  level_o == 0.
REQ-014 irq_o  output  1  level_o >= THRESH, or ovr_err_o set.
REQ-015 ovr_err_o  output  1  sticky overrun flag.
REQ-016 ovr_clr_i  input  1  clears ovr_err_o.

Function
- REQ-017 First-word-fall-through: rd_data_o SHALL present the oldest stored entry whenever rd_vld_o=1; value undefined-but-stable when empty.
- REQ-018 Push when wr_vld_i=1 and (not full, or pop in same cycle); word SHALL appear at head with rd_vld_o=1 in the cycle after the push edge if queue was empty (latency 1).
- REQ-019 Pop SHALL advance the read pointer on the handshake edge; next entry visible the following cycle.
- REQ-020 Write/read pointers SHALL be clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
- REQ-021 level_o SHALL be a registered counter: +1 push only, -1 pop only, unchanged on push+pop or neither; never exceeds DEPTH nor underflows.
- REQ-022 Push+pop same cycle when full: both accepted, level stays DEPTH, no overrun.
- REQ-023 Push+pop same cycle when empty: impossible (rd_vld_o=0), so push only, level 0 -> 1.
- REQ-024 Push attempt when full without pop: word dropped, storage and pointers unchanged, ovr_err_o SHALL be 1 from next cycle.
- REQ-025 ovr_err_o stays 1 until ovr_clr_i=1; on simultaneous clear and new overrun, set wins.
- REQ-026 rd_rdy_i while empty SHALL have no effect.
- REQ-027 full_o, empty_o, rd_vld_o, irq_o SHALL be derived from registered level_o/ovr_err_o only (no combinational path from wr_vld_i or rd_rdy_i).

Reset
- REQ-028 On rst=1 at a clock edge: pointers 0, level_o 0, empty_o 1, full_o 0, rd_vld_o 0, irq_o 0, ovr_err_o 0.
- REQ-029 Reset SHALL take priority over simultaneous push, pop, or clear; mid-operation reset discards all content.
- REQ-030 Storage array SHALL not require reset.

Structure
- REQ-031 WD_SIZE and RX_FIFO_DEPTH defaults SHALL live in the shared uart_defines include; clog2 helper reused from the shared function.
- REQ-032 Storage SHALL be a sub-module uart_rx_fifo_mem (write port synchronous, read port asynchronous), control/pointers/flags in uart_rx_fifo.

Verification
- REQ-033 After reset, single push 0xA5 -> next cycle rd_vld_o=1, rd_data_o=0xA5, level_o=1; pop -> empty_o=1 next cycle.
- REQ-034 16 pushes 0x00..0x0F, rd_rdy_i=0 -> full_o=1, level_o=16, irq_o=1 from 8th push; 17th push 0xFF -> ovr_err_o=1, then drain yields 0x00..0x0F in order, no 0xFF.
- REQ-035 Full queue, push 0x55 with pop same cycle -> level_o stays 16, ovr_err_o stays 0, 0x55 read last after draining.
- REQ-036 40 push/pop cycles with random rd_rdy_i -> order preserved across pointer wrap, level_o matches model every cycle.
- REQ-037 ovr_err_o=1, assert ovr_clr_i and overrun push same cycle -> ovr_err_o remains 1; clear alone -> 0 next cycle.
- REQ-038 Queue holding 5 words, rst=1 one cycle -> level_o=0, empty_o=1, rd_vld_o=0, ovr_err_o=0 next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART defaults and the clog2 helper for the receive FIFO
`ifndef UART_DEFINES_SV
`define UART_DEFINES_SV
`define WD_SIZE 8
`define RX_FIFO_DEPTH 16
`endif

package uart_rx_fifo_pkg;

    // Ceiling log2 usable in parameter expressions; returns at least 1 so ports stay non-empty.
    function automatic int unsigned uart_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// rtl/uart_rx_fifo_mem.sv - FIFO storage array, synchronous write, asynchronous read
module uart_rx_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int WD_SIZE = `WD_SIZE,
    parameter int DEPTH   = `RX_FIFO_DEPTH,
    parameter int AW      = uart_clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WD_SIZE-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [WD_SIZE-1:0] rd_data
);

    logic [WD_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with level, threshold IRQ and sticky overrun
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int WD_SIZE = `WD_SIZE,
    parameter int DEPTH   = `RX_FIFO_DEPTH,
    parameter int THRESH  = DEPTH / 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WD_SIZE-1:0]             wr_data_i,
    input  logic                           wr_vld_i,
    output logic [WD_SIZE-1:0]             rd_data_o,
    output logic                           rd_vld_o,
    input  logic                           rd_rdy_i,
    output logic [uart_clog2(DEPTH):0]     level_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           irq_o,
    output logic                           ovr_err_o,
    input  logic                           ovr_clr_i
);

    localparam int AW = uart_clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_L = LW'(THRESH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          ovr_err;
    logic          push;
    logic          pop;
    logic          ovr_set;

    // Status flags come only from registered state so no input-to-flag path exists.
    assign empty_o   = (level == '0);
    assign full_o    = (level == DEPTH_L);
    assign rd_vld_o  = ~empty_o;
    assign irq_o     = (level >= THRESH_L) | ovr_err;
    assign level_o   = level;
    assign ovr_err_o = ovr_err;

    // A pop frees the slot in the same edge, so a full queue can still accept a word.
    assign pop     = rd_vld_o & rd_rdy_i;
    assign push    = wr_vld_i & (~full_o | pop);
    assign ovr_set = wr_vld_i & full_o & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovr_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (ovr_set) begin
                ovr_err <= 1'b1;
            end else if (ovr_clr_i) begin
                ovr_err <= 1'b0;
            end
        end
    end

    uart_rx_fifo_mem #(
        .WD_SIZE (WD_SIZE),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push & ~rst),
        .wr_addr (wr_ptr),
        .wr_data (wr_data_i),
        .rd_addr (rd_ptr),
        .rd_data (rd_data_o)
    );

endmodule
